// File: rtl/sram_arbiter.sv
// sram_arbiter: arbitrates an instruction-fetch port and a data port onto a
// 16-bit asynchronous SRAM. Each 32-bit access becomes two halfword cycles
// (setup + strobe), low half first; byte-enable-free halves of writes are skipped.
module sram_arbiter #(
    parameter int unsigned STB_CYCLES = 1
) (
    input  logic        sck,
    input  logic        rst,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic [31:0] i_rdata,
    output logic        i_ack,
    input  logic        d_req,
    input  logic        d_rw,
    input  logic [3:0]  d_sel,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_ack,
    output logic [18:0] sram_addr,
    inout  wire logic [15:0] sram_data,
    output logic        sram_ce_n,
    output logic        sram_oe_n,
    output logic        sram_we_n,
    output logic        sram_ub_n,
    output logic        sram_lb_n
);

    typedef enum logic [2:0] {IDLE, LO_SETUP, LO_STB, HI_SETUP, HI_STB, ACK} state_t;

    state_t      state, state_nx;
    logic [3:0]  cnt, cnt_nx;
    logic        last_d;      // data port was the most recent grant
    logic        cur_d;       // access in flight belongs to the data port
    logic        cur_rw;
    logic [3:0]  cur_sel;
    logic [17:0] cur_word;
    logic [31:0] cur_wdata;
    logic [15:0] lo_buf;      // low halfword of a read, held until the word completes
    logic        grant, grant_d, half, drive;
    logic        lo_sample, hi_sample, ack_set, ack_to_d;
    logic        unused_addr_bits;

    assign unused_addr_bits = ^{i_addr[31:20], i_addr[1:0], d_addr[31:20], d_addr[1:0]};

    assign sram_addr = {cur_word, half};
    assign sram_data = drive ? (half ? cur_wdata[31:16] : cur_wdata[15:0]) : 'z;
    assign ack_to_d  = grant ? grant_d : cur_d;

    // FSM state and strobe down-counter
    always_ff @(posedge sck or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    // next-state, arbitration and SRAM control decode
    always_comb begin
        state_nx  = state;
        cnt_nx    = cnt;
        grant     = 1'b0;
        grant_d   = 1'b0;
        half      = 1'b0;
        drive     = 1'b0;
        lo_sample = 1'b0;
        hi_sample = 1'b0;
        sram_ce_n = 1'b1;
        sram_oe_n = 1'b1;
        sram_we_n = 1'b1;
        sram_ub_n = 1'b1;
        sram_lb_n = 1'b1;
        case (state)
            IDLE: begin
                if (i_req || d_req) begin
                    grant   = 1'b1;
                    grant_d = d_req && (!i_req || !last_d);
                    if (grant_d && d_rw && (d_sel == 4'b0000))
                        state_nx = ACK;
                    else if (grant_d && d_rw && (d_sel[1:0] == 2'b00))
                        state_nx = HI_SETUP;
                    else
                        state_nx = LO_SETUP;
                end
            end
            LO_SETUP: begin
                sram_ce_n              = 1'b0;
                {sram_ub_n, sram_lb_n} = cur_rw ? ~cur_sel[1:0] : 2'b00;
                drive                  = cur_rw;
                cnt_nx                 = 4'(STB_CYCLES - 1);
                state_nx               = LO_STB;
            end
            LO_STB: begin
                sram_ce_n              = 1'b0;
                sram_oe_n              = cur_rw;
                sram_we_n              = ~cur_rw;
                {sram_ub_n, sram_lb_n} = cur_rw ? ~cur_sel[1:0] : 2'b00;
                drive                  = cur_rw;
                if (cnt == 4'd0) begin
                    lo_sample = ~cur_rw;
                    state_nx  = (cur_rw && (cur_sel[3:2] == 2'b00)) ? ACK : HI_SETUP;
                end else begin
                    cnt_nx = cnt - 4'd1;
                end
            end
            HI_SETUP: begin
                half                   = 1'b1;
                sram_ce_n              = 1'b0;
                {sram_ub_n, sram_lb_n} = cur_rw ? ~cur_sel[3:2] : 2'b00;
                drive                  = cur_rw;
                cnt_nx                 = 4'(STB_CYCLES - 1);
                state_nx               = HI_STB;
            end
            HI_STB: begin
                half                   = 1'b1;
                sram_ce_n              = 1'b0;
                sram_oe_n              = cur_rw;
                sram_we_n              = ~cur_rw;
                {sram_ub_n, sram_lb_n} = cur_rw ? ~cur_sel[3:2] : 2'b00;
                drive                  = cur_rw;
                if (cnt == 4'd0) begin
                    hi_sample = ~cur_rw;
                    state_nx  = ACK;
                end else begin
                    cnt_nx = cnt - 4'd1;
                end
            end
            ACK:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        ack_set = (state_nx == ACK);
    end

    // request capture at grant, read data assembly and registered acks
    always_ff @(posedge sck or negedge rst) begin
        if (!rst) begin
            last_d    <= 1'b0;
            cur_d     <= 1'b0;
            cur_rw    <= 1'b0;
            cur_sel   <= '0;
            cur_word  <= '0;
            cur_wdata <= '0;
            lo_buf    <= '0;
            i_rdata   <= '0;
            d_rdata   <= '0;
            i_ack     <= 1'b0;
            d_ack     <= 1'b0;
        end else begin
            i_ack <= ack_set && !ack_to_d;
            d_ack <= ack_set && ack_to_d;
            if (grant) begin
                last_d    <= grant_d;
                cur_d     <= grant_d;
                cur_rw    <= grant_d && d_rw;
                cur_sel   <= d_sel;
                cur_word  <= grant_d ? d_addr[19:2] : i_addr[19:2];
                cur_wdata <= d_wdata;
            end
            if (lo_sample)
                lo_buf <= sram_data;
            // rdata changes only as the word completes, so it holds between acks
            if (hi_sample) begin
                if (cur_d)
                    d_rdata <= {sram_data, lo_buf};
                else
                    i_rdata <= {sram_data, lo_buf};
            end
        end
    end

endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: vector table, hand-written corner sequences and random
// traffic against a word-level memory model for sram_arbiter.
module tb_sram_arbiter;

    logic        sck = 1'b0;
    logic        rst;
    logic        i_req, i_ack, d_req, d_rw, d_ack;
    logic [31:0] i_addr, i_rdata, d_addr, d_wdata, d_rdata;
    logic [3:0]  d_sel;
    logic [18:0] sram_addr;
    wire  [15:0] sram_data;
    logic        sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n;

    logic        b_i_req, b_i_ack, b_d_req, b_d_rw, b_d_ack;
    logic [31:0] b_i_addr, b_i_rdata, b_d_addr, b_d_wdata, b_d_rdata;
    logic [3:0]  b_d_sel;
    logic [18:0] b_sram_addr;
    wire  [15:0] b_sram_data;
    logic        b_ce_n, b_oe_n, b_we_n, b_ub_n, b_lb_n;

    int checks = 0;
    int failures = 0;
    int last_setups, last_we, last_oe;
    int setup_total = 0, we_total = 0, oe_total = 0, overlap_total = 0;
    bit grant_order[$];

    always #5 sck = ~sck;

    sram_arbiter #(.STB_CYCLES(1)) u_dut (
        .sck(sck), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack),
        .d_req(d_req), .d_rw(d_rw), .d_sel(d_sel), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_rdata(d_rdata), .d_ack(d_ack),
        .sram_addr(sram_addr), .sram_data(sram_data), .sram_ce_n(sram_ce_n),
        .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n), .sram_ub_n(sram_ub_n),
        .sram_lb_n(sram_lb_n)
    );

    sram_arbiter #(.STB_CYCLES(3)) u_dut3 (
        .sck(sck), .rst(rst),
        .i_req(b_i_req), .i_addr(b_i_addr), .i_rdata(b_i_rdata), .i_ack(b_i_ack),
        .d_req(b_d_req), .d_rw(b_d_rw), .d_sel(b_d_sel), .d_addr(b_d_addr),
        .d_wdata(b_d_wdata), .d_rdata(b_d_rdata), .d_ack(b_d_ack),
        .sram_addr(b_sram_addr), .sram_data(b_sram_data), .sram_ce_n(b_ce_n),
        .sram_oe_n(b_oe_n), .sram_we_n(b_we_n), .sram_ub_n(b_ub_n),
        .sram_lb_n(b_lb_n)
    );

    function automatic logic [15:0] init_val(input logic [18:0] a);
        return a[15:0] ^ {13'h0, a[18:16]} ^ 16'h9E37;
    endfunction

    // Asynchronous SRAM model: reads are combinational, writes land at the clock edge
    logic [15:0] mem [0:524287];
    logic        mem_ready = 1'b0;
    assign sram_data = (!sram_ce_n && !sram_oe_n) ? mem[sram_addr] : 16'bz;

    always @(posedge sck) begin
        if (!mem_ready) begin
            for (int a = 0; a < 524288; a++) mem[a] <= init_val(19'(a));
            mem[19'h200] <= 16'h1234;
            mem[19'h201] <= 16'hABCD;
            mem[19'h0]   <= 16'hAAAA;
            mem[19'h1]   <= 16'hBBBB;
            mem[19'h4]   <= 16'h4444;
            mem[19'h5]   <= 16'h5555;
            mem[19'h6]   <= 16'h6666;
            mem[19'h7]   <= 16'h7777;
            mem_ready    <= 1'b1;
        end else if (!sram_ce_n && !sram_we_n) begin
            if (!sram_lb_n) mem[sram_addr][7:0]  <= sram_data[7:0];
            if (!sram_ub_n) mem[sram_addr][15:8] <= sram_data[15:8];
        end
    end

    // Read-only SRAM for the STB_CYCLES=3 instance: each halfword reads as ~address
    assign b_sram_data = (!b_ce_n && !b_oe_n) ? ~b_sram_addr[15:0] : 16'bz;

    // bus activity counters
    always @(posedge sck) begin
        if (!sram_ce_n && sram_oe_n && sram_we_n) setup_total <= setup_total + 1;
        if (!sram_we_n) we_total <= we_total + 1;
        if (!sram_oe_n) oe_total <= oe_total + 1;
        if (!sram_oe_n && !sram_we_n) overlap_total <= overlap_total + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // One complete handshake on a port; n = negedges from request until ack seen
    task automatic do_txn(input bit port_d, input logic rw, input logic [3:0] sel,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          output logic [31:0] rdata, output int n);
        int s0, w0, o0;
        logic [31:0] other0;
        bit other_ack, got;
        @(negedge sck);
        s0 = setup_total; w0 = we_total; o0 = oe_total;
        other0 = port_d ? i_rdata : d_rdata;
        if (port_d) begin
            d_req = 1'b1; d_rw = rw; d_sel = sel; d_addr = addr; d_wdata = wdata;
        end else begin
            i_req = 1'b1; i_addr = addr;
        end
        n = 0; other_ack = 1'b0; got = 1'b0;
        while (n < 40) begin
            @(negedge sck);
            n++;
            if (port_d ? i_ack : d_ack) other_ack = 1'b1;
            if (port_d ? d_ack : i_ack) begin
                got = 1'b1;
                break;
            end
        end
        rdata = port_d ? d_rdata : i_rdata;
        last_setups = setup_total - s0;
        last_we = we_total - w0;
        last_oe = oe_total - o0;
        check("ack_seen", got, 1'b1);
        d_req = 1'b0;
        i_req = 1'b0;
        @(negedge sck);
        check("ack_one_cycle", port_d ? d_ack : i_ack, 1'b0);
        check("rdata_hold", port_d ? d_rdata : i_rdata, rdata);
        check("other_ack_quiet", other_ack, 1'b0);
        check("other_rdata_kept", port_d ? i_rdata : d_rdata, other0);
    endtask

    task automatic requester(input bit port_d);
        int waited;
        for (int k = 0; k < 2; k++) begin
            waited = 0;
            while (waited < 14) begin
                @(negedge sck);
                waited++;
                if (port_d ? d_ack : i_ack) break;
            end
            check("contend_wait_le12", waited <= 12, 1'b1);
            check("contend_rdata", port_d ? d_rdata : i_rdata, 32'hABCD1234);
            grant_order.push_back(port_d);
            if (port_d) d_req = 1'b0; else i_req = 1'b0;
            @(negedge sck);
            if (k == 0) begin
                if (port_d) d_req = 1'b1; else i_req = 1'b1;
            end
        end
    endtask

    typedef struct {
        bit          port_d;
        logic        rw;
        logic [3:0]  sel;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        int          exp_n;
        int          exp_setups;
        int          exp_we;
        int          exp_oe;
    } vec_t;

    vec_t vecs [11];

    initial begin
        #1000000;
        $display("FAIL global_timeout: run still active at 1000000 time units");
        $fatal(1, "time limit reached");
    end

    initial begin
        logic [31:0] rd, addr, wdata;
        logic [17:0] pool [16];
        logic [31:0] ref_word [int unsigned];
        logic [17:0] w;
        logic [3:0]  sel;
        logic        rw;
        bit          port_d, seen;
        int          n, halves, run;
        int          runs[$];

        vecs[0]  = '{1'b1, 1'b0, 4'hF, 32'h00100400, 32'h0,        32'hABCD1234, 5, 2, 0, 2};
        vecs[1]  = '{1'b1, 1'b1, 4'h6, 32'h00100000, 32'h11223344, 32'h0,        5, 2, 2, 0};
        vecs[2]  = '{1'b0, 1'b0, 4'h0, 32'hFFF00001, 32'h0,        32'hBB2233AA, 5, 2, 0, 2};
        vecs[3]  = '{1'b1, 1'b1, 4'h3, 32'h00000008, 32'hCAFEF00D, 32'h0,        3, 1, 1, 0};
        vecs[4]  = '{1'b1, 1'b1, 4'h0, 32'h0000000C, 32'h12345678, 32'h0,        1, 0, 0, 0};
        vecs[5]  = '{1'b1, 1'b1, 4'hC, 32'h0000000C, 32'h76543210, 32'h0,        3, 1, 1, 0};
        vecs[6]  = '{1'b1, 1'b0, 4'hF, 32'h00000008, 32'h0,        32'h5555F00D, 5, 2, 0, 2};
        vecs[7]  = '{1'b0, 1'b0, 4'h0, 32'h0000000C, 32'h0,        32'h76546666, 5, 2, 0, 2};
        vecs[8]  = '{1'b1, 1'b1, 4'hF, 32'h000FFFFC, 32'hDEADBEEF, 32'h0,        5, 2, 2, 0};
        vecs[9]  = '{1'b0, 1'b0, 4'h0, 32'hFFFFFFFF, 32'h0,        32'hDEADBEEF, 5, 2, 0, 2};
        vecs[10] = '{1'b1, 1'b0, 4'h0, 32'h000FFFFE, 32'h0,        32'hDEADBEEF, 5, 2, 0, 2};

        // reset with both requesters already asking
        rst = 1'b0;
        i_req = 1'b1; i_addr = 32'h00100400;
        d_req = 1'b1; d_rw = 1'b0; d_sel = 4'hF; d_addr = 32'h00100400; d_wdata = '0;
        b_i_req = 1'b0; b_i_addr = '0;
        b_d_req = 1'b0; b_d_rw = 1'b0; b_d_sel = 4'hF; b_d_addr = '0; b_d_wdata = '0;
        repeat (2) @(negedge sck);
        check("rst_i_ack", i_ack, 1'b0);
        check("rst_d_ack", d_ack, 1'b0);
        check("rst_i_rdata", i_rdata, 32'h0);
        check("rst_d_rdata", d_rdata, 32'h0);
        check("rst_sram_ctl", {sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n}, 5'b11111);

        // contention from reset: expected grant order D,I,D,I
        rst = 1'b1;
        fork
            requester(1'b1);
            requester(1'b0);
        join
        check("contend_grants", grant_order.size(), 4);
        for (int k = 0; k < 4; k++)
            check($sformatf("contend_order%0d", k),
                  (k < grant_order.size()) ? grant_order[k] : 1'bx, (k % 2 == 0));

        // vector table
        for (int k = 0; k < 11; k++) begin
            do_txn(vecs[k].port_d, vecs[k].rw, vecs[k].sel, vecs[k].addr, vecs[k].wdata, rd, n);
            check($sformatf("vec%0d_latency", k), n, vecs[k].exp_n);
            check($sformatf("vec%0d_setups", k), last_setups, vecs[k].exp_setups);
            check($sformatf("vec%0d_we_cycles", k), last_we, vecs[k].exp_we);
            check($sformatf("vec%0d_oe_cycles", k), last_oe, vecs[k].exp_oe);
            if (!vecs[k].port_d || !vecs[k].rw)
                check($sformatf("vec%0d_rdata", k), rd, vecs[k].exp_rdata);
        end

        // reset while the low-half write strobe is active
        @(negedge sck);
        d_req = 1'b1; d_rw = 1'b1; d_sel = 4'hF; d_addr = 32'h00100400; d_wdata = 32'h55667788;
        seen = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge sck);
            if (!sram_we_n) begin
                seen = 1'b1;
                break;
            end
        end
        check("midop_reached_strobe", seen, 1'b1);
        rst = 1'b0;
        #1;
        check("midop_we_n_high", sram_we_n, 1'b1);
        check("midop_ce_n_high", sram_ce_n, 1'b1);
        d_req = 1'b0;
        seen = 1'b0;
        repeat (3) begin
            @(negedge sck);
            if (d_ack || i_ack) seen = 1'b1;
        end
        check("midop_no_ack", seen, 1'b0);
        check("midop_d_rdata_cleared", d_rdata, 32'h0);
        rst = 1'b1;
        do_txn(1'b1, 1'b0, 4'hF, 32'h00000000, 32'h0, rd, n);
        check("post_reset_read", rd, 32'hBB2233AA);
        check("post_reset_latency", n, 5);

        // STB_CYCLES=3 instance: oe low 3 cycles per half, ack 8 edges after grant
        @(negedge sck);
        b_d_req = 1'b1; b_d_addr = 32'h00000010;
        n = 0; run = 0; seen = 1'b0;
        while (n < 40) begin
            @(negedge sck);
            n++;
            if (!b_oe_n) run++;
            else if (run != 0) begin
                runs.push_back(run);
                run = 0;
            end
            if (b_d_ack) begin
                seen = 1'b1;
                break;
            end
        end
        b_d_req = 1'b0;
        check("stb3_ack_seen", seen, 1'b1);
        check("stb3_latency", n, 9);
        check("stb3_oe_runs", runs.size(), 2);
        check("stb3_oe_run_lo", (runs.size() > 0) ? runs[0] : 0, 3);
        check("stb3_oe_run_hi", (runs.size() > 1) ? runs[1] : 0, 3);
        check("stb3_rdata", b_d_rdata, 32'hFFF6FFF7);

        // random traffic against a word-level reference memory
        for (int k = 0; k < 16; k++) begin
            pool[k] = 18'($urandom_range(32'h1000, 32'h3FFF0));
            ref_word[int'(pool[k])] = {init_val({pool[k], 1'b1}), init_val({pool[k], 1'b0})};
        end
        for (int k = 0; k < 60; k++) begin
            port_d = ($urandom_range(0, 3) != 0);
            rw     = port_d ? 1'($urandom_range(0, 1)) : 1'b0;
            sel    = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 7) == 0) sel = 4'h0;
            w      = pool[$urandom_range(0, 15)];
            addr   = {12'($urandom), w, 2'($urandom)};
            wdata  = $urandom;
            halves = rw ? (int'(sel[1:0] != 2'b00) + int'(sel[3:2] != 2'b00)) : 2;
            do_txn(port_d, rw, sel, addr, wdata, rd, n);
            check($sformatf("rand%0d_latency", k), n, 1 + halves * 2);
            check($sformatf("rand%0d_setups", k), last_setups, halves);
            if (rw) begin
                for (int b = 0; b < 4; b++)
                    if (sel[b]) ref_word[int'(w)][8*b +: 8] = wdata[8*b +: 8];
            end else begin
                check($sformatf("rand%0d_rdata", k), rd, ref_word[int'(w)]);
            end
        end

        check("oe_we_never_both_low", overlap_total, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 SHALL have parameter STB_CYCLES, default 1, meaning the number of cycles each halfword strobe phase lasts (legal 1..15).
REQ-002 SHALL have port sck, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have ports i_req (in, 1), i_addr (in, 32), i_rdata (out, 32) and i_ack (out, 1): the instruction-fetch port, which is read-only.
REQ-005 SHALL have ports d_req (in, 1), d_rw (in, 1, 1=write), d_sel (in, 4, byte enables), d_addr (in, 32), d_wdata (in, 32), d_rdata (out, 32) and d_ack (out, 1): the data port.
REQ-006 SHALL have ports sram_addr (out, 19), sram_data (inout, 16), sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n and sram_lb_n (out, 1 each; all active-low).

Function
REQ-007 Handshake: a requester SHALL hold req and its inputs stable until it sees its ack, and SHALL drop req at the edge that ends the ack cycle.
REQ-008 Each ack SHALL be a registered pulse exactly one cycle wide; rdata SHALL be valid during the ack cycle and SHALL hold until the next ack on that port.
REQ-009 FSM states SHALL be IDLE, LO_SETUP, LO_STB, HI_SETUP, HI_STB and ACK.
REQ-010 Arbitration in IDLE:
- only one req high: that port is granted;
- both high: round-robin, granting the port not granted last;
- after reset, data wins the first tie.
REQ-011 Arbitration SHALL occur only in IDLE; req is ignored in every other state, including ACK.
REQ-012 Word mapping: sram_addr SHALL be {addr[19:2], h}, where h=0 is the low halfword (bits 15:0) and h=1 is the high halfword (bits 31:16); addr[31:20] and addr[1:0] are ignored.
REQ-013 Setup phase: each *_SETUP state SHALL last 1 cycle, driving sram_addr and sram_ce_n=0 with sram_we_n=1.
REQ-014 Strobe phase: each *_STB state SHALL last STB_CYCLES cycles (internal down-counter); reads hold sram_oe_n=0 and writes hold sram_we_n=0.
REQ-015 Reads SHALL use sram_ub_n=sram_lb_n=0 and SHALL sample sram_data at the last edge of the strobe phase into the proper half of the granted port's rdata.
REQ-016 Writes SHALL map byte enables as follows:
- low half: sram_lb_n=~d_sel[0], sram_ub_n=~d_sel[1];
- high half: sram_lb_n=~d_sel[2], sram_ub_n=~d_sel[3].
REQ-017 Write data: sram_data SHALL be driven with the selected d_wdata halfword during write SETUP and STB only, and SHALL be high-Z in all other states and for all reads.
REQ-018 Half skipping on writes:
- d_sel[1:0]==0: the low half is skipped (IDLE goes to HI_SETUP);
- d_sel[3:2]==0: the high half is skipped (LO_STB goes to ACK);
- d_sel==0: IDLE goes to ACK with no SRAM cycle.
REQ-019 Reads SHALL always access both halves.
REQ-020 Transitions: IDLE to LO_SETUP on grant; LO_SETUP to LO_STB; LO_STB to HI_SETUP; HI_SETUP to HI_STB; HI_STB to ACK; ACK to IDLE.
REQ-021 Latency (STB_CYCLES=1, full word): with the grant edge as E0, ack SHALL be high in the cycle after E4; the general formula is ack after 2*(1+STB_CYCLES) cycles.
REQ-022 In IDLE and ACK: sram_ce_n=sram_oe_n=sram_we_n=1, sram_ub_n=sram_lb_n=1, sram_data high-Z.
REQ-023 The non-granted port's ack SHALL stay 0 and its rdata SHALL be unchanged.

Reset
REQ-024 While rst=0, the block SHALL immediately (asynchronously) go to IDLE.
REQ-025 Reset outputs:
- i_ack=d_ack=0;
- i_rdata=d_rdata=0;
- all SRAM controls high and sram_data high-Z;
- strobe counter=0;
- last-grant register=instruction.
REQ-026 Reset asserted mid-access SHALL abort the access with no ack; a write in progress may leave the SRAM partially written.
REQ-027 After rst rises, the first rising edge SHALL sample requests normally.

Verification
REQ-028 Read: SRAM model word 0x100 holds 0x1234 at halfword address 0x200 and 0xABCD at 0x201; d_req read with d_addr=0x00100400 -> d_rdata=0xABCD1234 with d_ack in the cycle after E4, and sram_we_n never low.
REQ-029 Write with byte enables: d_rw=1, d_sel=4'b0110, d_wdata=0x11223344, d_addr=0x00100000 -> half 0x0 written with only ub active (0x33); half 0x1 written with only lb active (0x22).
REQ-030 Half skip: d_sel=4'b0011 write -> exactly one SETUP+STB pair (low half), and ack 2 cycles earlier than a full-word access; d_sel=0 -> ack in the cycle after grant and sram_ce_n never low.
REQ-031 Contention: i_req and d_req held high from reset -> grant order D,I,D,I; each requester gets an ack within 12 cycles.
REQ-032 Reset mid-op: assert rst during LO_STB of a write -> sram_we_n rises and sram_data floats within the same cycle; no ack is produced; after release, a new read completes normally.
REQ-033 Parameter sweep: STB_CYCLES=3 -> sram_oe_n is low for exactly 3 cycles per half and the ack comes 8 cycles after grant.
